fwd_source_producer: RTL and testbench
======================================

FWD_SOURCE_PRODUCER -- requirements
Module: fwd_source_producer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: enable  in  1  pipeline advance; 0 = hold all state and outputs.
REQ-004 SHALL have ports: flush  in  1  kill the instruction entering the ALU slot.
REQ-005 SHALL have ports: EX_WB_Valid  in  1  instruction in EX writes a register.
REQ-006 SHALL have ports: EX_Is_Load  in  1  EX instruction is a load; value comes from memory.
REQ-007 SHALL have ports: EX_Dst_NUM  in  4  EX destination register number.
REQ-008 SHALL have ports: EX_Result  in  16  ALU result of the EX instruction.
REQ-009 SHALL have ports: MEM_Data  in  16  memory read data for the load occupying slot 1.
REQ-010 SHALL have ports: ID_Src_1_NUM, ID_Src_2_NUM  in  4 each  decode-stage source numbers.
REQ-011 SHALL have ports: ID_Src_1_Used, ID_Src_2_Used  in  1 each  source actually read.
REQ-012 SHALL have ports: Old_Dst_1_NUM  out  4, Old_Dst_1_VALUE  out  16, M2R1  out  1  (ALU-out slot, newest).
REQ-013 SHALL have ports: Old_Dst_2_NUM  out  4, Old_Dst_2_VALUE  out  16, M2R2  out  1  (memory-out slot, older).
REQ-014 SHALL have ports: Stall  out  1  load-use stall request to fetch/decode.

Function
REQ-015 Slot 1 SHALL capture {valid=EX_WB_Valid, load=EX_Is_Load, NUM=EX_Dst_NUM, VALUE=EX_Result} on each clk edge with enable=1.
REQ-016 Slot 1 SHALL capture valid=0 when flush=1 or the FSM is in STALL (bubble); flush has priority over capture.
REQ-017 M2R1 SHALL equal slot1.valid AND NOT slot1.load; a load in slot 1 SHALL never be published as forwardable.
REQ-018 Slot 2 SHALL capture slot 1 every enabled edge; VALUE = MEM_Data if slot1.load, else slot1.VALUE.
REQ-019 M2R2 SHALL equal slot2.valid; outputs SHALL be registered (latency 1 edge slot 1, 2 edges slot 2).
REQ-020 Identical NUM in both slots SHALL be published unchanged; slot 1 is newer by definition.
REQ-021 FSM states: IDLE, STALL.
REQ-022 IDLE->STALL when enable, EX_WB_Valid, EX_Is_Load, not flush, and (ID_Src_1_Used and ID_Src_1_NUM==EX_Dst_NUM or ID_Src_2_Used and ID_Src_2_NUM==EX_Dst_NUM).
REQ-023 STALL->IDLE unconditionally on the next enabled edge; Stall SHALL be 1 exactly while in STALL (one cycle per hazard).
REQ-024 Back-to-back hazards SHALL be impossible: in STALL the hazard check is ignored.
REQ-025 flush in STALL SHALL return FSM to IDLE and clear Stall on that edge.
REQ-026 enable=0 SHALL freeze slots and FSM, including mid-stall.
REQ-027 Register numbers SHALL be compared as full 4-bit values; no register is hard-wired.

Reset
REQ-028 rst=0 at a clk edge SHALL clear both slots (valid, load, NUM=0, VALUE=16'h0000), M2R1=M2R2=0, Stall=0, FSM=IDLE, overriding enable and flush.
REQ-029 Reset mid-stall SHALL drop Stall the following cycle with no residual bubble.

Structure
REQ-030 Shared package fwd_pkg SHALL hold REG_NUM_W=4, DATA_W=16 and the FSM state type.
REQ-031 One sub-module fwd_slot (valid/load/NUM/VALUE register with bubble input) SHALL be instantiated twice.

Verification
REQ-032 ALU chain: EX_WB_Valid=1, EX_Dst_NUM=3, EX_Result=16'h1234 -> next cycle M2R1=1, NUM1=3, VALUE1=1234; following cycle M2R2=1, NUM2=3, VALUE2=1234.
REQ-033 Load-use: EX load to R5, ID_Src_2_NUM=5 used -> Stall=1 for one cycle, slot 1 gets load with M2R1=0; MEM_Data=16'hBEEF -> M2R2=1, NUM2=5, VALUE2=BEEF; no second stall.
REQ-034 No hazard: EX load to R5, ID sources R6/R7 -> Stall stays 0.
REQ-035 Flush: flush=1 with valid EX to R2 -> M2R1=0 next cycle; flush during STALL -> Stall=0 next cycle.
REQ-036 Freeze/reset: enable=0 for 3 cycles mid-stall -> all outputs constant; rst=0 -> all outputs 0 after one edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared widths and FSM state type for the forwarding source producer
package fwd_pkg;
  localparam int REG_NUM_W = 4;
  localparam int DATA_W = 16;
  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;
endpackage

// File: rtl/fwd_slot.sv
// fwd_slot: one forwarding slot register (valid/load/num/value) with a bubble input
import fwd_pkg::*;
module fwd_slot (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 bubble,
  input  logic                 d_valid,
  input  logic                 d_load,
  input  logic [REG_NUM_W-1:0] d_num,
  input  logic [DATA_W-1:0]    d_value,
  output logic                 q_valid,
  output logic                 q_load,
  output logic [REG_NUM_W-1:0] q_num,
  output logic [DATA_W-1:0]    q_value
);
  // capture on enabled edges; a bubble kills valid and load so nothing is forwarded
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_load  <= 1'b0;
      q_num   <= '0;
      q_value <= '0;
    end else if (en) begin
      q_valid <= d_valid & ~bubble;
      q_load  <= d_load & ~bubble;
      q_num   <= d_num;
      q_value <= d_value;
    end
  end
endmodule

// File: rtl/fwd_source_producer.sv
// fwd_source_producer: two-slot forwarding source with one-cycle load-use stall
import fwd_pkg::*;
module fwd_source_producer (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 EX_WB_Valid,
  input  logic                 EX_Is_Load,
  input  logic [REG_NUM_W-1:0] EX_Dst_NUM,
  input  logic [DATA_W-1:0]    EX_Result,
  input  logic [DATA_W-1:0]    MEM_Data,
  input  logic [REG_NUM_W-1:0] ID_Src_1_NUM,
  input  logic [REG_NUM_W-1:0] ID_Src_2_NUM,
  input  logic                 ID_Src_1_Used,
  input  logic                 ID_Src_2_Used,
  output logic [REG_NUM_W-1:0] Old_Dst_1_NUM,
  output logic [DATA_W-1:0]    Old_Dst_1_VALUE,
  output logic                 M2R1,
  output logic [REG_NUM_W-1:0] Old_Dst_2_NUM,
  output logic [DATA_W-1:0]    Old_Dst_2_VALUE,
  output logic                 M2R2,
  output logic                 Stall
);
  state_t state, state_nx;
  logic hazard;
  logic s1_valid, s1_load, s2_valid, s2_load;
  fwd_slot u_slot1 (
    .clk(clk), .rst(rst), .en(enable), .bubble(flush | (state == STALL)),
    .d_valid(EX_WB_Valid), .d_load(EX_Is_Load), .d_num(EX_Dst_NUM), .d_value(EX_Result),
    .q_valid(s1_valid), .q_load(s1_load), .q_num(Old_Dst_1_NUM), .q_value(Old_Dst_1_VALUE)
  );
  fwd_slot u_slot2 (
    .clk(clk), .rst(rst), .en(enable), .bubble(1'b0),
    .d_valid(s1_valid), .d_load(s1_load), .d_num(Old_Dst_1_NUM),
    .d_value(s1_load ? MEM_Data : Old_Dst_1_VALUE),
    .q_valid(s2_valid), .q_load(s2_load), .q_num(Old_Dst_2_NUM), .q_value(Old_Dst_2_VALUE)
  );
  assign M2R1 = s1_valid & ~s1_load;
  assign M2R2 = s2_valid;
  assign Stall = (state == STALL);
  // load-use detection; STALL always falls back to IDLE so hazards never chain
  always_comb begin
    hazard = EX_WB_Valid & EX_Is_Load & ~flush &
             ((ID_Src_1_Used & (ID_Src_1_NUM == EX_Dst_NUM)) |
              (ID_Src_2_Used & (ID_Src_2_NUM == EX_Dst_NUM)));
    state_nx = state;
    if (enable) state_nx = (state == IDLE && hazard) ? STALL : IDLE;
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
endmodule

// File: tb/tb_fwd_source_producer.sv
// tb_fwd_source_producer: directed self-checking bench for the forwarding source producer
module tb_fwd_source_producer;
  logic clk = 1'b0, rst, enable, flush;
  logic EX_WB_Valid, EX_Is_Load;
  logic [3:0] EX_Dst_NUM, ID_Src_1_NUM, ID_Src_2_NUM;
  logic [15:0] EX_Result, MEM_Data;
  logic ID_Src_1_Used, ID_Src_2_Used;
  logic [3:0] Old_Dst_1_NUM, Old_Dst_2_NUM;
  logic [15:0] Old_Dst_1_VALUE, Old_Dst_2_VALUE;
  logic M2R1, M2R2, Stall;
  int passed = 0, total = 0;
  fwd_source_producer dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .EX_WB_Valid(EX_WB_Valid), .EX_Is_Load(EX_Is_Load), .EX_Dst_NUM(EX_Dst_NUM),
    .EX_Result(EX_Result), .MEM_Data(MEM_Data),
    .ID_Src_1_NUM(ID_Src_1_NUM), .ID_Src_2_NUM(ID_Src_2_NUM),
    .ID_Src_1_Used(ID_Src_1_Used), .ID_Src_2_Used(ID_Src_2_Used),
    .Old_Dst_1_NUM(Old_Dst_1_NUM), .Old_Dst_1_VALUE(Old_Dst_1_VALUE), .M2R1(M2R1),
    .Old_Dst_2_NUM(Old_Dst_2_NUM), .Old_Dst_2_VALUE(Old_Dst_2_VALUE), .M2R2(M2R2),
    .Stall(Stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic ld, input logic [3:0] d, input logic [15:0] r);
    EX_WB_Valid = v;
    EX_Is_Load = ld;
    EX_Dst_NUM = d;
    EX_Result = r;
  endtask
  task automatic id(input logic u1, input logic [3:0] n1, input logic u2, input logic [3:0] n2);
    ID_Src_1_Used = u1;
    ID_Src_1_NUM = n1;
    ID_Src_2_Used = u2;
    ID_Src_2_NUM = n2;
  endtask
  initial begin
    rst = 1'b0; enable = 1'b1; flush = 1'b1; MEM_Data = 16'h0;
    ex(1'b1, 1'b0, 4'h7, 16'hAAAA);
    id(1'b0, 4'h0, 1'b0, 4'h0);
    step();
    chk("rst_m2r1", {15'b0, M2R1}, 16'd0);
    chk("rst_m2r2", {15'b0, M2R2}, 16'd0);
    chk("rst_stall", {15'b0, Stall}, 16'd0);
    chk("rst_num1", {12'b0, Old_Dst_1_NUM}, 16'd0);
    chk("rst_val1", Old_Dst_1_VALUE, 16'h0000);
    chk("rst_num2", {12'b0, Old_Dst_2_NUM}, 16'd0);
    chk("rst_val2", Old_Dst_2_VALUE, 16'h0000);
    rst = 1'b1; flush = 1'b0;
    ex(1'b1, 1'b0, 4'd3, 16'h1234);
    step();
    chk("alu_m2r1", {15'b0, M2R1}, 16'd1);
    chk("alu_num1", {12'b0, Old_Dst_1_NUM}, 16'd3);
    chk("alu_val1", Old_Dst_1_VALUE, 16'h1234);
    chk("alu_stall", {15'b0, Stall}, 16'd0);
    ex(1'b0, 1'b0, 4'd0, 16'h0);
    step();
    chk("alu_m2r2", {15'b0, M2R2}, 16'd1);
    chk("alu_num2", {12'b0, Old_Dst_2_NUM}, 16'd3);
    chk("alu_val2", Old_Dst_2_VALUE, 16'h1234);
    chk("alu_m2r1_gone", {15'b0, M2R1}, 16'd0);
    ex(1'b1, 1'b1, 4'd5, 16'h0000);
    id(1'b0, 4'd0, 1'b1, 4'd5);
    MEM_Data = 16'hBEEF;
    step();
    chk("lu_stall", {15'b0, Stall}, 16'd1);
    chk("lu_m2r1_load", {15'b0, M2R1}, 16'd0);
    chk("lu_num1", {12'b0, Old_Dst_1_NUM}, 16'd5);
    step();
    chk("lu_stall_once", {15'b0, Stall}, 16'd0);
    chk("lu_m2r2", {15'b0, M2R2}, 16'd1);
    chk("lu_num2", {12'b0, Old_Dst_2_NUM}, 16'd5);
    chk("lu_val2", Old_Dst_2_VALUE, 16'hBEEF);
    chk("lu_bubble", {15'b0, M2R1}, 16'd0);
    ex(1'b0, 1'b0, 4'd0, 16'h0);
    id(1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk("lu_no_second", {15'b0, Stall}, 16'd0);
    chk("lu_bubble_m2r2", {15'b0, M2R2}, 16'd0);
    ex(1'b1, 1'b1, 4'd5, 16'h0);
    id(1'b1, 4'd6, 1'b1, 4'd7);
    step();
    chk("nohaz_stall", {15'b0, Stall}, 16'd0);
    ex(1'b1, 1'b1, 4'hD, 16'h0);
    id(1'b1, 4'h5, 1'b0, 4'hD);
    step();
    chk("fullnum_stall", {15'b0, Stall}, 16'd0);
    ex(1'b1, 1'b0, 4'd2, 16'h2222);
    id(1'b0, 4'd0, 1'b0, 4'd0);
    flush = 1'b1;
    step();
    chk("flush_m2r1", {15'b0, M2R1}, 16'd0);
    flush = 1'b0;
    ex(1'b1, 1'b1, 4'd4, 16'h0);
    id(1'b1, 4'd4, 1'b0, 4'd0);
    step();
    chk("fs_stall", {15'b0, Stall}, 16'd1);
    flush = 1'b1;
    step();
    chk("fs_cleared", {15'b0, Stall}, 16'd0);
    chk("fs_m2r1", {15'b0, M2R1}, 16'd0);
    flush = 1'b0;
    ex(1'b1, 1'b1, 4'd9, 16'h0);
    id(1'b1, 4'd9, 1'b0, 4'd0);
    step();
    chk("frz_stall0", {15'b0, Stall}, 16'd1);
    enable = 1'b0;
    ex(1'b1, 1'b0, 4'hA, 16'h5555);
    id(1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_stall", {15'b0, Stall}, 16'd1);
      chk("frz_m2r1", {15'b0, M2R1}, 16'd0);
      chk("frz_num1", {12'b0, Old_Dst_1_NUM}, 16'd9);
    end
    rst = 1'b0;
    step();
    chk("rst2_stall", {15'b0, Stall}, 16'd0);
    chk("rst2_m2r1", {15'b0, M2R1}, 16'd0);
    chk("rst2_m2r2", {15'b0, M2R2}, 16'd0);
    chk("rst2_val1", Old_Dst_1_VALUE, 16'h0000);
    chk("rst2_num2", {12'b0, Old_Dst_2_NUM}, 16'd0);
    rst = 1'b1; enable = 1'b1;
    ex(1'b1, 1'b0, 4'd1, 16'h0F0F);
    step();
    chk("post_rst_stall", {15'b0, Stall}, 16'd0);
    chk("post_rst_m2r1", {15'b0, M2R1}, 16'd1);
    chk("post_rst_val1", Old_Dst_1_VALUE, 16'h0F0F);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
